axi_addr_resp: RTL

Responder end of the AXI write-address channel. It accepts address/length bursts issued by the stream-to-memory address initiator, queues them, and expands each burst into per-beat memory addresses with a last-beat flag on a valid/ready request port. It sits between the address initiator and a memory model or beat-level memory controller in simulation and on-chip test paths.

---
 rtl/axi_addr_resp_if.sv | 26 ++
 rtl/axi_addr_resp.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axi_addr_resp_if.sv
// Write-address channel and beat-request bundle between address initiator,
// axi_addr_resp, and the beat-level memory side.
interface axi_addr_resp_if #(
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_ADDR_WIDTH = 32
);
   logic                      axi_aready;
   logic [AXI_ADDR_WIDTH-1:0] axi_aaddr;
   logic [AXI_LEN_WIDTH-1:0]  axi_alen;
   logic                      axi_avalid;
   logic [AXI_ADDR_WIDTH-1:0] mem_addr;
   logic                      mem_last;
   logic                      mem_valid;
   logic                      mem_ready;
   logic                      busy;

   modport slave (
      input  axi_aaddr, axi_alen, axi_avalid, mem_ready,
      output axi_aready, mem_addr, mem_last, mem_valid, busy
   );

   modport master (
      output axi_aaddr, axi_alen, axi_avalid, mem_ready,
      input  axi_aready, mem_addr, mem_last, mem_valid, busy
   );
endinterface

// File: rtl/axi_addr_resp.sv
// Queues write-address bursts and expands them into per-beat requests; AXI_ADDR_RESP_ALIGN_EN bus-aligns start addresses.
// First beat 2 cycles after the address handshake; aready drops while the queue is full, beats hold while mem_ready is low.
module axi_addr_resp #(
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 256,
   parameter int QUEUE_LOG2     = 2
) (
   input  logic              clk,
   input  logic              rst,
   axi_addr_resp_if.slave    bus
);
   localparam int DEPTH = 1 << QUEUE_LOG2;
   localparam int CW    = QUEUE_LOG2 + 1;
   localparam int BYTES = AXI_DATA_WIDTH / 8;
   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_INC = AXI_ADDR_WIDTH'(BYTES);

   typedef struct packed {
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [AXI_LEN_WIDTH-1:0]  len;
   } burst_t;

   typedef enum logic [1:0] {
      IDLE = 2'b01,
      BEAT = 2'b10
   } state_t;

   burst_t                    queue_mem [DEPTH];
   logic [QUEUE_LOG2-1:0]     wr_ptr;
   logic [QUEUE_LOG2-1:0]     rd_ptr;
   logic [CW-1:0]             count;
   logic [CW-1:0]             count_nxt;
   logic                      full;
   logic                      empty;
   logic                      run;

   state_t                    state;
   state_t                    state_nxt;
   logic [AXI_ADDR_WIDTH-1:0] beat_addr;
   logic [AXI_LEN_WIDTH-1:0]  beat_cnt;
   logic                      beat_last;
   logic                      last_hs;
   logic                      push;
   logic                      pop;
   burst_t                    head;
   logic [AXI_ADDR_WIDTH-1:0] load_addr;

   assign bus.axi_aready = run & ~full;
   assign push      = bus.axi_avalid & bus.axi_aready;
   assign beat_last = (beat_cnt == '0);
   assign last_hs   = (state == BEAT) & bus.mem_ready & beat_last;
   // Pop on the last-beat handshake too, so back-to-back bursts run without a bubble.
   assign pop       = ~empty & ((state == IDLE) | last_hs);
   assign head      = queue_mem[rd_ptr];

`ifdef AXI_ADDR_RESP_ALIGN_EN
   assign load_addr = head.addr & ~(BEAT_INC - 1'b1);
`else
   assign load_addr = head.addr;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) run <= 1'b0;
      else      run <= 1'b1;
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + CW'(1);
      else if (pop && !push) count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage needs no reset: entries are only read behind the registered empty flag.
   always_ff @(posedge clk) begin
      if (push) queue_mem[wr_ptr] <= '{addr: bus.axi_aaddr, len: bus.axi_alen};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = BEAT;
         BEAT:    if (last_hs && empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_addr <= '0;
         beat_cnt  <= '0;
      end else if (pop) begin
         beat_addr <= load_addr;
         beat_cnt  <= head.len;
      end else if ((state == BEAT) && bus.mem_ready && !beat_last) begin
         beat_addr <= beat_addr + BEAT_INC;
         beat_cnt  <= beat_cnt - 1'b1;
      end
   end

   always_comb begin
      bus.mem_valid = (state == BEAT);
      bus.mem_last  = (state == BEAT) & beat_last;
      bus.mem_addr  = beat_addr;
      bus.busy      = ~empty | (state == BEAT);
   end
endmodule
